// File: rtl/exit_gate_billing.sv
// Exit-side controller for the 4-spot lot: validates the leaving spot, bills it from the spot's
// elapsed-time counter, waits for payment, runs the exit door and releases the spot.
module exit_gate_billing #(
   parameter int unsigned UNIT_SHIFT  = 20,
   parameter logic [15:0] RATE        = 16'd5,
   parameter int unsigned OPEN_CYCLES = 100,
   parameter int unsigned PAY_TIMEOUT = 1000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        exit,
   input  logic [1:0]  switch,
   input  logic [3:0]  occupied,
   input  logic [63:0] spot0_time,
   input  logic [63:0] spot1_time,
   input  logic [63:0] spot2_time,
   input  logic [63:0] spot3_time,
   input  logic        pay_ok,
   output logic [15:0] fee,
   output logic        fee_valid,
   output logic        exit_door_open,
   output logic        exit_light,
   output logic        release_o,      // "release" is a reserved word
   output logic [1:0]  release_spot,
   output logic        reject,
   output logic        timeout,
   output logic        busy
);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_BILL, S_OPEN, S_RELEASE} state_t;

   localparam int PW = $clog2(PAY_TIMEOUT + 1);
   localparam int OW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
   localparam logic [PW-1:0] PAY_LAST  = PW'(PAY_TIMEOUT);
   localparam logic [OW-1:0] OPEN_LAST = OW'(OPEN_CYCLES - 1);

   state_t        state_q, state_d;
   logic          exit_q, exit_d;
   logic [1:0]    sp_q, sp_d;
   logic [PW-1:0] pay_cnt_q, pay_cnt_d, pay_nxt;
   logic [OW-1:0] open_cnt_q, open_cnt_d;
   logic [15:0]   fee_q, fee_d;
   logic          fee_valid_q, fee_valid_d;
   logic          door_q, door_d;
   logic          release_q, release_d;
   logic [1:0]    release_spot_q, release_spot_d;
   logic          reject_q, reject_d;
   logic          timeout_q, timeout_d;
   logic          busy_q, busy_d;

   logic          req;
   logic [63:0]   time_sel;
   logic [63:0]   units;
   logic [79:0]   prod;
   logic [15:0]   fee_calc;

   assign req = exit & ~exit_q;

   // Fee for the latched spot: started billing units, minimum one unit, saturated to 16 bits.
   always_comb begin
      case (sp_q)
         2'd0:    time_sel = spot0_time;
         2'd1:    time_sel = spot1_time;
         2'd2:    time_sel = spot2_time;
         default: time_sel = spot3_time;
      endcase
      units = (time_sel >> UNIT_SHIFT) + 64'(time_sel[UNIT_SHIFT-1:0] != '0);
      if (time_sel == '0) units = 64'd1;
      prod     = 80'(units) * 80'(RATE);
      fee_calc = (|prod[79:16]) ? 16'hFFFF : prod[15:0];
   end

   always_comb begin
      // NOTE: every _d defaults to hold (or to 0 for pulses) first so no path infers a latch.
      state_d        = state_q;
      exit_d         = exit;
      sp_d           = sp_q;
      pay_cnt_d      = pay_cnt_q;
      open_cnt_d     = open_cnt_q;
      fee_d          = fee_q;
      fee_valid_d    = fee_valid_q;
      door_d         = door_q;
      release_d      = 1'b0;
      release_spot_d = release_spot_q;
      reject_d       = 1'b0;
      timeout_d      = 1'b0;
      pay_nxt        = pay_cnt_q + PW'(1);

      case (state_q)
         S_IDLE: begin
            if (req) begin
               sp_d    = switch;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (occupied[sp_q]) begin
               fee_d       = fee_calc;
               fee_valid_d = 1'b1;
               pay_cnt_d   = '0;
               state_d     = S_BILL;
            end else begin
               reject_d = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_BILL: begin
            // Payment on the timeout edge still opens the door.
            if (pay_ok) begin
               fee_valid_d = 1'b0;
               door_d      = 1'b1;
               open_cnt_d  = '0;
               state_d     = S_OPEN;
            end else if (pay_nxt == PAY_LAST) begin
               timeout_d   = 1'b1;
               fee_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               pay_cnt_d = pay_nxt;
            end
         end
         S_OPEN: begin
            if (open_cnt_q == OPEN_LAST) begin
               door_d         = 1'b0;
               release_d      = 1'b1;
               release_spot_d = sp_q;
               state_d        = S_RELEASE;
            end else begin
               open_cnt_d = open_cnt_q + OW'(1);
            end
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q        <= S_IDLE;
         exit_q         <= 1'b0;
         sp_q           <= '0;
         pay_cnt_q      <= '0;
         open_cnt_q     <= '0;
         fee_q          <= '0;
         fee_valid_q    <= 1'b0;
         door_q         <= 1'b0;
         release_q      <= 1'b0;
         release_spot_q <= '0;
         reject_q       <= 1'b0;
         timeout_q      <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         exit_q         <= exit_d;
         sp_q           <= sp_d;
         pay_cnt_q      <= pay_cnt_d;
         open_cnt_q     <= open_cnt_d;
         fee_q          <= fee_d;
         fee_valid_q    <= fee_valid_d;
         door_q         <= door_d;
         release_q      <= release_d;
         release_spot_q <= release_spot_d;
         reject_q       <= reject_d;
         timeout_q      <= timeout_d;
         busy_q         <= busy_d;
      end
   end

   assign fee            = fee_q;
   assign fee_valid      = fee_valid_q;
   assign exit_door_open = door_q;
   assign exit_light     = door_q;
   assign release_o      = release_q;
   assign release_spot   = release_spot_q;
   assign reject         = reject_q;
   assign timeout        = timeout_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_exit_gate_billing.sv
// Scoreboard bench for exit_gate_billing: stimulus queues expected output events, a negedge
// monitor turns DUT output activity into events and compares them in order.
module tb_exit_gate_billing;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        exit = 1'b0;
   logic [1:0]  switch = 2'd0;
   logic [3:0]  occupied = 4'd0;
   logic [63:0] spot0_time = '0, spot1_time = '0, spot2_time = '0, spot3_time = '0;
   logic        pay_ok = 1'b0;
   logic [15:0] fee;
   logic        fee_valid, exit_door_open, exit_light, release_o, reject, timeout, busy;
   logic [1:0]  release_spot;

   exit_gate_billing #(
      .UNIT_SHIFT(4), .RATE(16'd5), .OPEN_CYCLES(3), .PAY_TIMEOUT(8)
   ) dut (
      .CLK(CLK), .RST(RST), .exit(exit), .switch(switch), .occupied(occupied),
      .spot0_time(spot0_time), .spot1_time(spot1_time),
      .spot2_time(spot2_time), .spot3_time(spot3_time),
      .pay_ok(pay_ok), .fee(fee), .fee_valid(fee_valid),
      .exit_door_open(exit_door_open), .exit_light(exit_light),
      .release_o(release_o), .release_spot(release_spot),
      .reject(reject), .timeout(timeout), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // a/b meaning: FEE a=fee; FVAL/REJ/TMO b=width; DOOR a=light width b=door width; REL a=spot b=width
   typedef enum int {EV_FEE, EV_FVAL, EV_REJ, EV_TMO, EV_DOOR, EV_REL} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      int unsigned a;
      int unsigned b;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void push_ev(input ev_kind_t k, input int unsigned a, input int unsigned b);
      ev_t e;
      e.kind = k;
      e.a    = a;
      e.b    = b;
      sb.push_back(e);
   endfunction

   task automatic got(input ev_kind_t k, input int unsigned a, input int unsigned b);
      ev_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_%s actual=a:%0d,b:%0d required=no_event", k.name(), a, b);
      end else begin
         e = sb.pop_front();
         check($sformatf("%s.kind", e.kind.name()), 64'(k), 64'(e.kind));
         check($sformatf("%s.a", e.kind.name()), 64'(a), 64'(e.a));
         check($sformatf("%s.b", e.kind.name()), 64'(b), 64'(e.b));
      end
   endtask

   // Monitor: measures pulse/level widths and reports each finished event.
   initial begin
      int unsigned w_fv = 0, w_rej = 0, w_tmo = 0, w_door = 0, w_light = 0, w_rel = 0;
      logic [1:0]  rel_seen = '0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            w_fv = 0; w_rej = 0; w_tmo = 0; w_door = 0; w_light = 0; w_rel = 0;
         end else begin
            if (fee_valid) begin
               if (w_fv == 0) got(EV_FEE, 32'(fee), 0);
               w_fv++;
            end else if (w_fv != 0) begin
               got(EV_FVAL, 0, w_fv);
               w_fv = 0;
            end
            if (reject) w_rej++;
            else if (w_rej != 0) begin got(EV_REJ, 0, w_rej); w_rej = 0; end
            if (timeout) w_tmo++;
            else if (w_tmo != 0) begin got(EV_TMO, 0, w_tmo); w_tmo = 0; end
            if (exit_door_open) w_door++;
            if (exit_light) w_light++;
            if (!exit_door_open && !exit_light && (w_door != 0 || w_light != 0)) begin
               got(EV_DOOR, w_light, w_door);
               w_door = 0;
               w_light = 0;
            end
            if (release_o) begin
               w_rel++;
               rel_seen = release_spot;
            end else if (w_rel != 0) begin
               got(EV_REL, 32'(rel_seen), w_rel);
               w_rel = 0;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic exit_pulse(input logic [1:0] sp);
      @(negedge CLK);
      switch = sp;
      exit   = 1'b1;
      @(negedge CLK);
      exit   = 1'b0;
   endtask

   task automatic wait_fee(input string name);
      int n = 0;
      while (!fee_valid && n < 10) begin
         @(negedge CLK);
         n++;
      end
      check({name, "_fee_valid_seen"}, 64'(fee_valid), 64'd1);
   endtask

   task automatic pay_after(input int d);
      repeat (d) @(negedge CLK);
      pay_ok = 1'b1;
      @(negedge CLK);
      pay_ok = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_fee"}, 64'(fee), 64'd0);
      check({name, "_fee_valid"}, 64'(fee_valid), 64'd0);
      check({name, "_door"}, 64'(exit_door_open), 64'd0);
      check({name, "_light"}, 64'(exit_light), 64'd0);
      check({name, "_release"}, 64'(release_o), 64'd0);
      check({name, "_release_spot"}, 64'(release_spot), 64'd0);
      check({name, "_reject"}, 64'(reject), 64'd0);
      check({name, "_timeout"}, 64'(timeout), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] corner_t [4];
      logic [15:0] corner_fee [4];
      corner_t[0] = 64'd0;  corner_fee[0] = 16'd5;
      corner_t[1] = 64'd16; corner_fee[1] = 16'd5;
      corner_t[2] = 64'd17; corner_fee[2] = 16'd10;
      corner_t[3] = 64'hFFFF_FFFF_FFFF_FFFF; corner_fee[3] = 16'hFFFF;

      // Power-on reset
      tick(3);
      #2 RST = 1'b0;
      check_all_zero("reset");

      // Occupied spot 1, t=33 -> 3 units -> fee 15; immediate payment
      occupied   = 4'b0010;
      spot1_time = 64'd33;
      push_ev(EV_FEE, 15, 0);
      push_ev(EV_FVAL, 0, 1);
      push_ev(EV_DOOR, 3, 3);
      push_ev(EV_REL, 1, 1);
      exit_pulse(2'd1);
      wait_fee("paid");
      check("paid_busy", 64'(busy), 64'd1);
      pay_after(0);
      tick(12);
      check("paid_drained", 64'(sb.size()), 64'd0);

      // Empty spot 2 -> single reject pulse
      occupied = 4'b0000;
      push_ev(EV_REJ, 0, 1);
      exit_pulse(2'd2);
      tick(8);
      check("reject_drained", 64'(sb.size()), 64'd0);

      // No payment -> timeout after 8 BILL cycles
      occupied = 4'b0010;
      push_ev(EV_FEE, 15, 0);
      push_ev(EV_FVAL, 0, 8);
      push_ev(EV_TMO, 0, 1);
      exit_pulse(2'd1);
      wait_fee("tmo");
      tick(14);
      check("tmo_drained", 64'(sb.size()), 64'd0);

      // Payment on the 8th BILL cycle wins over timeout
      push_ev(EV_FEE, 15, 0);
      push_ev(EV_FVAL, 0, 8);
      push_ev(EV_DOOR, 3, 3);
      push_ev(EV_REL, 1, 1);
      exit_pulse(2'd1);
      wait_fee("late_pay");
      pay_after(7);
      tick(12);
      check("late_pay_drained", 64'(sb.size()), 64'd0);

      // Fee corners, one per spot so each spot timer is selected
      occupied   = 4'b1111;
      spot0_time = corner_t[0];
      spot1_time = corner_t[1];
      spot2_time = corner_t[2];
      spot3_time = corner_t[3];
      for (int i = 0; i < 4; i++) begin
         push_ev(EV_FEE, 32'(corner_fee[i]), 0);
         push_ev(EV_FVAL, 0, 1);
         push_ev(EV_DOOR, 3, 3);
         push_ev(EV_REL, i, 1);
         exit_pulse(2'(i));
         wait_fee($sformatf("corner%0d", i));
         pay_after(0);
         tick(10);
         check($sformatf("corner%0d_drained", i), 64'(sb.size()), 64'd0);
      end

      // Exit edges in BILL and OPEN are ignored; fee and spot stay those of spot 2
      push_ev(EV_FEE, 10, 0);
      push_ev(EV_FVAL, 0, 3);
      push_ev(EV_DOOR, 3, 3);
      push_ev(EV_REL, 2, 1);
      exit_pulse(2'd2);
      wait_fee("ignore");
      switch = 2'd3;
      exit   = 1'b1;
      @(negedge CLK);
      exit   = 1'b0;
      @(negedge CLK);
      pay_ok = 1'b1;
      @(negedge CLK);
      pay_ok = 1'b0;
      exit   = 1'b1;
      @(negedge CLK);
      exit   = 1'b0;
      check("ignore_door_open", 64'(exit_door_open), 64'd1);
      check("ignore_fee_held", 64'(fee), 64'd10);
      tick(10);
      check("ignore_drained", 64'(sb.size()), 64'd0);

      // Reset during OPEN: door drops without a clock edge, no release follows
      push_ev(EV_FEE, 5, 0);
      push_ev(EV_FVAL, 0, 1);
      exit_pulse(2'd0);
      wait_fee("rst_open");
      pay_after(0);
      @(negedge CLK);
      check("rst_open_door_pre", 64'(exit_door_open), 64'd1);
      #2 RST = 1'b1;
      #1 check_all_zero("rst_open");
      tick(2);
      #2 RST = 1'b0;
      tick(8);
      check("rst_open_drained", 64'(sb.size()), 64'd0);

      // Held exit level after reset triggers once (empty lot -> one reject) and never again
      occupied = 4'b0000;
      push_ev(EV_REJ, 0, 1);
      @(negedge CLK);
      switch = 2'd1;
      exit   = 1'b1;
      tick(15);
      exit   = 1'b0;
      tick(4);
      check("held_exit_busy", 64'(busy), 64'd0);
      check("held_exit_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
